// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and round-key index helper for the
// iterative AES-256 round sequencer.
package aes_pkg;

  localparam int unsigned NR      = 14;   // rounds per block (AES-256)
  localparam int unsigned BLOCK_W = 128;  // AES block width
  localparam int unsigned KA_W    = 4;    // round-key address width
  localparam int unsigned RND_W   = 5;    // round counter width, never wraps within a block

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Encryption walks the key schedule upward, decryption walks it downward.
  function automatic logic [KA_W-1:0] rk_index(input logic mode, input logic [RND_W-1:0] rnd);
    logic [RND_W-1:0] idx;
    idx = mode ? rnd : (RND_W'(NR) - rnd);
    return KA_W'(idx);
  endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-256 controller. Accepts one block plus mode, runs the shared
// single-round datapath through NR rounds using keys from an external
// expanded-key store, and returns the result over a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clr                   synchronous abort back to IDLE
//   in_valid/in_ready     input block handshake; in_data, in_enc (1=encrypt)
//   out_valid/out_ready   result handshake; out_data
//   busy                  block in flight
//   rk_addr/rk_data       round-key store read (combinational)
//   rnd_in, rnd_key,      round datapath inputs (state, key, mode,
//   rnd_enc_en,           final-round flag)
//   rnd_f_rnd_en
//   rnd_out               round datapath result
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned ROUND_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_enc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy,
  output logic [KA_W-1:0]    rk_addr,
  input  logic [BLOCK_W-1:0] rk_data,
  output logic [BLOCK_W-1:0] rnd_in,
  output logic [BLOCK_W-1:0] rnd_key,
  output logic               rnd_enc_en,
  output logic               rnd_f_rnd_en,
  input  logic [BLOCK_W-1:0] rnd_out
);

  localparam int unsigned LAT_W = (ROUND_LAT < 1) ? 1 : $clog2(ROUND_LAT + 1);

  seq_state_e         state,  state_nxt;
  logic [BLOCK_W-1:0] st,     st_nxt;
  logic               mode,   mode_nxt;
  logic [RND_W-1:0]   rnd,    rnd_nxt;
  logic [LAT_W-1:0]   lat,    lat_nxt;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      st    <= '0;
      mode  <= 1'b0;
      rnd   <= '0;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      st    <= st_nxt;
      mode  <= mode_nxt;
      rnd   <= rnd_nxt;
      lat   <= lat_nxt;
    end
  end

  // Next-state and register update logic; clr overrides every transition.
  always_comb begin
    state_nxt = state;
    st_nxt    = st;
    mode_nxt  = mode;
    rnd_nxt   = rnd;
    lat_nxt   = lat;
    if (clr) begin
      state_nxt = IDLE;
      st_nxt    = '0;
      rnd_nxt   = '0;
      lat_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            // Initial AddRoundKey folded into acceptance.
            st_nxt    = in_data ^ rk_data;
            mode_nxt  = in_enc;
            rnd_nxt   = RND_W'(1);
            lat_nxt   = '0;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (lat == LAT_W'(ROUND_LAT)) begin
            st_nxt  = rnd_out;
            lat_nxt = '0;
            if (rnd == RND_W'(NR)) begin
              state_nxt = DONE;
            end else begin
              rnd_nxt = rnd + RND_W'(1);
            end
          end else begin
            lat_nxt = lat + LAT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode from the state registers.
  always_comb begin
    in_ready     = (state == IDLE);
    busy         = (state != IDLE);
    out_valid    = (state == DONE);
    out_data     = (state == DONE) ? st : '0;
    // In IDLE the key for the initial AddRoundKey depends on the incoming mode.
    rk_addr      = (state == IDLE) ? rk_index(in_enc, RND_W'(0)) : rk_index(mode, rnd);
    rnd_in       = st;
    rnd_key      = rk_data;
    rnd_enc_en   = mode;
    rnd_f_rnd_en = (state == RUN) && (rnd == RND_W'(NR));
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: models the round datapath and
// expanded-key ROM, and checks results against a whole-block AES-256 model.
module tb_aes_round_sequencer;

  localparam int RL    = 1;   // round datapath latency
  localparam int NR_TB = 14;

  logic         clk, rst_n, clr;
  logic         in_valid, in_ready, in_enc;
  logic [127:0] in_data;
  logic         out_valid, out_ready, busy;
  logic [127:0] out_data;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data, rnd_in, rnd_key, rnd_out;
  logic         rnd_enc_en, rnd_f_rnd_en;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk_rom [16];
  logic [127:0] dp_pipe [RL];

  aes_round_sequencer #(.ROUND_LAT(RL)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_enc       (in_enc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .rk_addr      (rk_addr),
    .rk_data      (rk_data),
    .rnd_in       (rnd_in),
    .rnd_key      (rnd_key),
    .rnd_enc_en   (rnd_enc_en),
    .rnd_f_rnd_en (rnd_f_rnd_en),
    .rnd_out      (rnd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES primitives ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = inv ? isbox[s[8*i +: 8]] : sbox[s[8*i +: 8]];
    return o;
  endfunction

  // Byte i of the block is the i-th byte from the MSB; column c = bytes 4c..4c+3.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*src)) +: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   acc;
    if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[8*(15-(j+4*c)) +: 8];
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(m[(j - i + 4) % 4], a[j]);
        o[8*(15-(i+4*c)) +: 8] = acc;
      end
    end
    return o;
  endfunction

  // Single round as performed by the external round datapath.
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic enc, input logic fin);
    logic [127:0] t;
    if (enc) begin
      t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (!fin) t = mix_cols(t, 1'b0);
      return t ^ k;
    end
    t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
    if (!fin) t = mix_cols(t, 1'b1);
    return t;
  endfunction

  // Whole-block FIPS-197 cipher / inverse cipher.
  function automatic logic [127:0] aes_ref(input logic [127:0] blk, input logic enc);
    logic [127:0] s;
    if (enc) begin
      s = blk ^ rk_rom[0];
      for (int r = 1; r < NR_TB; r++)
        s = mix_cols(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk_rom[r];
      return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk_rom[NR_TB];
    end
    s = blk ^ rk_rom[NR_TB];
    for (int r = NR_TB - 1; r > 0; r--)
      s = mix_cols(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk_rom[r], 1'b1);
    return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk_rom[0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_rom[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk_rom[15] = '0;
  endtask

  // ---------------- environment models ----------------
  assign rk_data = rk_rom[rk_addr];

  always_ff @(posedge clk) begin
    dp_pipe[0] <= round_fn(rnd_in, rnd_key, rnd_enc_en, rnd_f_rnd_en);
    for (int i = 1; i < RL; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign rnd_out = dp_pipe[RL-1];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic start_block(input logic [127:0] data, input logic enc, input bit chk_seq,
                             input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_data  = data;
    in_enc   = enc;
    #1;
    if (chk_seq) check({tag, "_rk_addr_idle"}, 128'(rk_addr), 128'(enc ? 0 : NR_TB));
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Inputs wander during the run; the controller must ignore them.
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_enc   = 1'($urandom_range(0, 1));
  endtask

  // stall_mode: 0 accept at once, 1 random out_ready, 2 hold off 5 cycles.
  task automatic finish_block(input logic enc, input logic [127:0] exp, input int stall_mode,
                              input bit chk_seq, input string tag);
    int  k, rd, cyc;
    bit  done;
    k = 0;
    while (!out_valid && k < 400) begin
      if (chk_seq) begin
        rd = k / (RL + 1) + 1;
        check({tag, "_rk_addr"}, 128'(rk_addr), 128'(enc ? rd : NR_TB - rd));
        check({tag, "_final"}, 128'(rnd_f_rnd_en), 128'(rd == NR_TB));
      end
      @(posedge clk); #1; k++;
    end
    check({tag, "_latency"}, 128'(k), 128'(NR_TB * (RL + 1)));
    cyc = 0; done = 0;
    while (!done && cyc < 64) begin
      case (stall_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc >= 5);
      endcase
      check({tag, "_out_valid"}, 128'(out_valid), 128'(1));
      check({tag, "_out_data"}, out_data, exp);
      check({tag, "_in_ready_done"}, 128'(in_ready), 128'(0));
      check({tag, "_busy_done"}, 128'(busy), 128'(1));
      done = out_ready && out_valid;
      @(posedge clk); #1; cyc++;
    end
    out_ready = 1'b0;
    check({tag, "_handshake"}, 128'(done), 128'(1));
    check({tag, "_idle_after"}, 128'({out_valid, busy, in_ready}), 128'(3'b001));
    if (stall_mode == 2) check({tag, "_stall_cycles"}, 128'(cyc), 128'(6));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_out_data"}, out_data, 128'(0));
    check({tag, "_rnd_in"}, rnd_in, 128'(0));
    check({tag, "_enc_en"}, 128'(rnd_enc_en), 128'(0));
    check({tag, "_f_rnd"}, 128'(rnd_f_rnd_en), 128'(0));
  endtask

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [127:0] d;
    logic         e;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_enc = 1'b1; out_ready = 1'b0;
    build_sbox();
    expand_key(FIPS_KEY);

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    check("reset_rk_addr", 128'(rk_addr), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("post_reset");

    // FIPS-197 C.3 encrypt and decrypt with key-order / final-flag tracking.
    start_block(FIPS_PT, 1'b1, 1'b1, "fips_enc");
    finish_block(1'b1, FIPS_CT, 0, 1'b1, "fips_enc");
    start_block(FIPS_CT, 1'b0, 1'b1, "fips_dec");
    finish_block(1'b0, FIPS_PT, 0, 1'b1, "fips_dec");

    // Consumer stalls for 5 cycles.
    start_block(FIPS_PT, 1'b1, 1'b0, "stall");
    finish_block(1'b1, FIPS_CT, 2, 1'b0, "stall");

    // Async reset during round 7.
    start_block(FIPS_PT, 1'b1, 1'b0, "arst");
    repeat (6 * (RL + 1)) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_block(FIPS_PT, 1'b1, 1'b0, "arst_next");
    finish_block(1'b1, FIPS_CT, 0, 1'b0, "arst_next");

    // clr during round 10 with a competing block presented.
    start_block(FIPS_CT, 1'b0, 1'b0, "clr");
    repeat (9 * (RL + 1)) @(posedge clk);
    #1;
    clr = 1'b1; in_valid = 1'b1; in_data = FIPS_PT; in_enc = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check("clr_in_ready", 128'(in_ready), 128'(1));
    check("clr_busy", 128'(busy), 128'(0));
    check("clr_out_valid", 128'(out_valid), 128'(0));
    check("clr_st", rnd_in, 128'(0));
    start_block(FIPS_PT, 1'b1, 1'b0, "clr_next");
    finish_block(1'b1, FIPS_CT, 0, 1'b0, "clr_next");

    // Random back-to-back traffic under a random key.
    expand_key({$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()});
    for (int b = 0; b < 1000; b++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      e = 1'($urandom_range(0, 1));
      start_block(d, e, 1'b0, "rand");
      finish_block(e, aes_ref(d, e), 1, 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
